// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// The IMEM_LOADER_CHECKSUM_EN macro adds the CHECK state to the FSM encoding.
package imem_loader_pkg;

  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// The master is the byte source; the slave is the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Merges accepted stream bytes into a little-endian word by lane index
// and flags the byte that completes the word.
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  byte_t             byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear) begin
      byte_cnt_d = '0;
    end else if (accept) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  assign word_done = accept && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word      = word_q;

  // NOTE: the word register is reset too, because it drives wr_data and every output must read 0 in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: streams bytes into consecutive instruction words
// while the PC is held, then pulses the PC reset. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  imem_loader_if.slave      in_if,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pc_hold,
  output logic              pc_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_words_q, num_words_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              in_ready;
  logic              idle_like, len_ok, load_go, asm_accept, word_done, last_word;
  logic [DATA_W-1:0] asm_word;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign len_ok     = (num_words != '0) && (num_words <= MAX_WORDS);
  assign load_go    = idle_like && start && len_ok;
  assign asm_accept = (state_q == ST_RECV) && in_if.in_valid;
  assign last_word  = (word_cnt_q + (ADDR_W + 1)'(1)) == num_words_q;

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (load_go),
    .accept    (asm_accept),
    .byte_in   (in_if.in_data),
    .word      (asm_word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  byte_t cksum_q, cksum_d;
  logic  cksum_ok;

  always_comb begin
    cksum_d = cksum_q;
    if (load_go)         cksum_d = '0;
    else if (asm_accept) cksum_d = cksum_q ^ in_if.in_data;
  end

  assign cksum_ok = (in_if.in_data == cksum_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    word_cnt_d  = word_cnt_q;
    in_ready    = 1'b0;
    wr_en       = 1'b0;
    pc_hold     = 1'b0;
    pc_reset    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done    = (state_q == ST_DONE);
        err     = (state_q == ST_ERR);
        // A bad or partial image keeps the CPU frozen.
        pc_hold = (state_q == ST_ERR);
        if (start) begin
          if (len_ok) begin
            state_d     = ST_RECV;
            num_words_d = num_words;
            word_cnt_d  = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_RECV: begin
        in_ready = 1'b1;
        pc_hold  = 1'b1;
        busy     = 1'b1;
        if (word_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        pc_hold    = 1'b1;
        busy       = 1'b1;
        word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RELEASE;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        pc_hold  = 1'b1;
        busy     = 1'b1;
        if (in_if.in_valid) state_d = cksum_ok ? ST_RELEASE : ST_ERR;
      end
`endif
      ST_RELEASE: begin
        pc_reset = 1'b1;
        pc_hold  = 1'b1;
        busy     = 1'b1;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_if.in_ready = in_ready;
  assign wr_addr        = word_cnt_q[ADDR_W-1:0];
  assign wr_data        = asm_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_words_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them; the loader model is plain arithmetic.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CKSUM = 1;
`else
  localparam int CKSUM = 0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          wr_en, pc_hold, pc_reset, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  imem_loader_if s_if ();

  imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .in_if     (s_if),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_hold   (pc_hold),
    .pc_reset  (pc_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int  total = 0, bad = 0;
  wr_t exp_q[$];
  int  wr_cnt, prc_cnt, acc_total, first_acc;
  bit  prev_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the next expected word and land right after a word's 4th accept.
  initial begin
    prev_acc = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_acc = 1'b0;
        continue;
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", wr_addr, '1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        check("wr_after_accept", prev_acc, 1);
        check("wr_byte_count", acc_total, 4 * (wr_cnt + 1));
        check("wr_pc_hold", pc_hold, 1);
        wr_cnt++;
      end
      if (pc_reset) begin
        check("pc_reset_overlap", wr_en, 0);
        check("pc_reset_hold", pc_hold, 1);
        prc_cnt++;
      end
      prev_acc = s_if.in_valid && s_if.in_ready;
      if (prev_acc) begin
        if (first_acc < 0) first_acc = cyc;
        acc_total++;
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    wr_cnt    = 0;
    prc_cnt   = 0;
    acc_total = 0;
    first_acc = -1;
  endtask

  // mode 0: in_valid held high, 1: toggled every cycle, 2: random
  task automatic send_bytes(input byte_t b[$], input int mode, input bit poke_start, output int sent);
    int idx;
    int budget;
    bit tog;
    bit v;
    idx    = 0;
    tog    = 1'b1;
    budget = 10 * b.size() + 40;
    while (idx < b.size() && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      s_if.in_valid = v;
      s_if.in_data  = v ? b[idx] : byte_t'($urandom);
      if (poke_start && idx == 2) begin
        start     = 1'b1;
        num_words = '0;
      end
      @(negedge clock);
      if (v && s_if.in_ready) idx++;
      @(posedge clock);
      #1;
      start = 1'b0;
      budget--;
    end
    s_if.in_valid = 1'b0;
    sent = idx;
  endtask

  task automatic do_load(input int n, input logic [DW-1:0] words[$], input int mode,
                         input bit bad_ck, input bit poke);
    bit    valid, exp_ok;
    byte_t b[$];
    byte_t x, bt;
    int    sent, lat;
    valid  = (n >= 1) && (n <= DEPTH);
    exp_ok = valid;
    clear_sb();
    start     = 1'b1;
    num_words = (AW + 1)'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
    if (valid) begin
      check("start_clears_err", err, 0);
      check("start_clears_done", done, 0);
      x = '0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{addr: AW'(i), data: words[i]});
        for (int k = 0; k < 4; k++) begin
          bt = byte_t'(words[i] >> (8 * k));
          b.push_back(bt);
          x ^= bt;
        end
      end
      if (CKSUM != 0) begin
        b.push_back(bad_ck ? (x ^ 8'h01) : x);
        exp_ok = !bad_ck;
      end
      send_bytes(b, mode, poke, sent);
      check("bytes_sent", sent, b.size());
    end
    for (int i = 0; i < 40 && !(done || err); i++) @(negedge clock);
    lat = cyc - first_acc;
    check("end_done_or_err", done || err, 1);
    check("end_done", done, exp_ok);
    check("end_err", err, !exp_ok);
    check("end_pc_hold", pc_hold, !exp_ok);
    check("end_busy", busy, 0);
    check("pc_reset_pulses", prc_cnt, exp_ok ? 1 : 0);
    check("write_count", wr_cnt, valid ? n : 0);
    check("sb_empty", exp_q.size(), 0);
    if (exp_ok && mode == 0) check("load_latency", lat, 5 * n + 1 + CKSUM);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [DW-1:0] words[$];
    byte_t         b[$];
    logic [DW-1:0] w0, w1;
    int            sent, n;

    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    clear_sb();
    repeat (2) @(posedge clock);
    #1;
    check("reset_ctrl", {wr_en, pc_hold, pc_reset, busy, done, err, s_if.in_ready}, '0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single word, little-endian assembly.
    words = '{32'h12345678};
    do_load(1, words, 0, 1'b0, 1'b0);

    // Full depth: 32 writes, addresses 0..31, 161-cycle load.
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(DW'(i));
    do_load(DEPTH, words, 0, 1'b0, 1'b0);

    // Stalled source, plus a start poke while busy that must be ignored.
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    do_load(4, words, 1, 1'b0, 1'b1);

    // Invalid lengths, then a valid load clears err.
    do_load(0, words, 0, 1'b0, 1'b0);
    do_load(DEPTH + 1, words, 0, 1'b0, 1'b0);
    words.delete();
    for (int i = 0; i < 2; i++) words.push_back($urandom);
    do_load(2, words, 2, 1'b0, 1'b0);

    // Reset after 6 bytes of a 3-word load: only word 0 reaches memory.
    clear_sb();
    start     = 1'b1;
    num_words = (AW + 1)'(3);
    @(posedge clock);
    #1;
    start = 1'b0;
    w0 = $urandom;
    w1 = $urandom;
    exp_q.push_back('{addr: '0, data: w0});
    b.delete();
    for (int k = 0; k < 4; k++) b.push_back(byte_t'(w0 >> (8 * k)));
    for (int k = 0; k < 2; k++) b.push_back(byte_t'(w1 >> (8 * k)));
    send_bytes(b, 0, 1'b0, sent);
    check("mid_bytes_sent", sent, 6);
    check("pre_reset_pc_hold", pc_hold, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_ctrl", {wr_en, pc_hold, pc_reset, busy, done, err, s_if.in_ready}, '0);
    check("mid_reset_writes", wr_cnt, 1);
    check("mid_reset_sb_empty", exp_q.size(), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    words = '{32'h00000001};
    do_load(1, words, 0, 1'b0, 1'b0);
    do_load(1, words, 0, 1'b1, 1'b0);
`endif

    // Randomized loads against the reference model.
    repeat (5) begin
      n = $urandom_range(1, DEPTH);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      do_load(n, words, $urandom_range(0, 2), 1'($urandom_range(0, 1)) && (CKSUM != 0),
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them to consecutive instruction-memory addresses starting at 0, holding the program counter frozen for the whole load. When the load finishes it pulses the PC reset so execution starts at address 0 with the new program; it is the writer-side counterpart to the PC-driven instruction read path.

## Interface
- ADDR_W, 5, instruction-memory address width; matches PC counter width
- DATA_W, 32, instruction word width; fixed at 4 bytes
- clock  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle load request; sampled only in IDLE, DONE or ERR
- num_words  input  ADDR_W+1  words to load, valid range 1..2^ADDR_W; sampled on accepted start
- in_valid  input  1  in_data holds a byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  assembled word
- pc_hold  output  1  drives the PC disable input
- pc_reset  output  1  one-cycle pulse to the PC reset input
- busy  output  1  load in progress
- done  output  1  load completed successfully; held until the next accepted start
- err  output  1  load rejected or checksum failed; held until the next accepted start

## Operation
- Reset values: all outputs 0; state IDLE; word and byte counters 0; checksum 0.
- States: IDLE, RECV, WRITE, CHECK (only with the macro), RELEASE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - If num_words is 0 or greater than 2^ADDR_W, go to ERR.
  - Otherwise go to RECV. Latch num_words, clear counters and checksum, clear done and err.
- RECV: in_ready=1, pc_hold=1, busy=1.
  - Each accepted byte goes into lane byte_cnt (byte 0 = bits 7:0) and is XORed into the checksum.
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE: one cycle; in_ready=0; wr_en=1, wr_addr=word_cnt, wr_data=assembled word.
  - Then word_cnt increments.
  - If this was the last word, go to CHECK (macro) or RELEASE; otherwise return to RECV.
- RELEASE: pc_reset=1 and pc_hold=1 for exactly one cycle, then DONE.
- DONE: done=1; pc_hold=0, busy=0.
- ERR: err=1; pc_hold=1 so the CPU stays frozen on a bad or partial image.
- start while busy is ignored. in_valid outside RECV/CHECK is ignored, with in_ready=0.
- Reset mid-load: immediate return to IDLE with pc_hold=0. Words already written stay in memory and are not rolled back.
- wr_addr never wraps: at most 2^ADDR_W writes per load; the last address is 2^ADDR_W-1.

## Timing
- Minimum 5 cycles per word with in_valid held high: 4 accept cycles plus 1 write cycle.
- Minimum load time is 5·N + 1 cycles from the first accept to done rising (+1 with CHECK).
- wr_en is registered: it asserts the cycle after the 4th byte is accepted.
- done or err rises the cycle after RELEASE or CHECK. pc_hold falls in the same cycle done rises.
- pc_reset never overlaps wr_en.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the FSM enters CHECK with in_ready=1 and accepts one extra byte.
  - The byte must equal the XOR of all image bytes. Match goes to RELEASE; mismatch goes to ERR with no pc_reset.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum logic; the last WRITE goes directly to RELEASE.

## Structure
- Shared package `imem_loader_pkg`: state enum, ADDR_W/DATA_W defaults, BYTES_PER_WORD=4.
- Sub-module `byte_assembler`: lane shift/merge, byte_cnt and word-complete flag.
- The FSM, word counter and checksum stay in imem_loader.

## Test plan
- Single-word load:
  - Stimulus: num_words=1; bytes 0x78,0x56,0x34,0x12 back-to-back.
  - Required response: one wr_en with addr 0 and data 0x12345678; pc_reset pulse; done=1; pc_hold 1→0.
- Full depth with wrap check:
  - Stimulus: num_words=32, word i = i.
  - Required response: 32 writes on addresses 0..31, no address 0 rewrite; done after 161 cycles.
- Stalled source:
  - Stimulus: in_valid toggled 1/0 every cycle.
  - Required response: data unchanged; the write for each word lands the cycle after its 4th accept.
- Invalid length:
  - Stimulus: num_words=0, then num_words=33.
  - Required response: err=1, no wr_en, pc_hold=1; a later valid start clears err.
- Reset mid-load:
  - Stimulus: assert reset after 6 bytes of a 3-word load.
  - Required response: outputs to 0 in the same cycle; exactly one write (addr 0) was issued.
- Checksum (macro on):
  - Stimulus: image 0x00000001 with checksum byte 0x01.
  - Required response: done.
  - Stimulus: same image with checksum byte 0x00.
  - Required response: err=1, no pc_reset, pc_hold stays 1.
